// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer of {PC, instruction} entries between program memory and decode
module fetch_queue #(
  parameter int          XLEN  = 32,
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic                       Clock,
  input  logic                       nReset,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [XLEN-1:0]            push_PC,
  input  logic [31:0]                push_inst,
  output logic                       pop_valid,
  input  logic                       pop_ready,
  output logic [XLEN-1:0]            PC_out,
  output logic [31:0]                instruction_out,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic [XLEN-1:0] pc_hold;
  logic            push, pop;
  // Handshakes depend only on registered count, so there is no pop_ready -> push_ready path
  assign push_ready      = count != CW'(DEPTH);
  assign pop_valid       = count != '0;
  assign push            = push_valid && push_ready && !flush;
  assign pop             = pop_valid && pop_ready && !flush;
  assign PC_out          = pop_valid ? pc_mem[rd_ptr] : pc_hold;
  assign instruction_out = pop_valid ? inst_mem[rd_ptr] : NOP;
  // Storage array is never reset; validity is tracked by count alone
  always_ff @(posedge Clock) begin
    if (push) begin
      pc_mem[wr_ptr]   <= push_PC;
      inst_mem[wr_ptr] <= push_inst;
    end
  end
  // Pointers, occupancy and the last presented PC (held while the queue is empty)
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      pc_hold <= '0;
    end else begin
      if (pop_valid) pc_hold <= pc_mem[rd_ptr];
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue with DEPTH=4
module tb_fetch_queue;
  logic        Clock = 0;
  logic        nReset;
  logic        push_valid, push_ready, pop_valid, pop_ready, flush;
  logic [31:0] push_PC, push_inst, PC_out, instruction_out;
  logic [2:0]  count;
  int          n_assert = 0, n_fail = 0;

  fetch_queue dut (
    .Clock(Clock), .nReset(nReset), .push_valid(push_valid), .push_ready(push_ready),
    .push_PC(push_PC), .push_inst(push_inst), .pop_valid(pop_valid), .pop_ready(pop_ready),
    .PC_out(PC_out), .instruction_out(instruction_out), .flush(flush), .count(count)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    nReset = 0; push_valid = 0; pop_ready = 0; flush = 0; push_PC = 0; push_inst = 0;
    #12;
    chk("rst_count", count, 0);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_push_ready", push_ready, 1);
    chk("rst_pc", PC_out, 0);
    chk("rst_inst", instruction_out, 32'h13);
    nReset = 1;
    // single entry latency
    push_valid = 1; push_PC = 32'h100; push_inst = 32'h00500093;
    #1;
    chk("lat_pre_valid", pop_valid, 0);
    step();
    push_valid = 0;
    chk("lat_valid", pop_valid, 1);
    chk("lat_pc", PC_out, 32'h100);
    chk("lat_inst", instruction_out, 32'h00500093);
    chk("lat_count", count, 1);
    pop_ready = 1;
    step();
    pop_ready = 0;
    chk("empty_count", count, 0);
    chk("empty_inst", instruction_out, 32'h13);
    chk("empty_pc_hold", PC_out, 32'h100);
    // fill to full, overflow push ignored, drain in order
    push_valid = 1;
    for (int i = 0; i < 4; i++) begin
      push_PC = 32'(i * 4); push_inst = 32'h1000 + 32'(i);
      step();
    end
    chk("full_count", count, 4);
    chk("full_push_ready", push_ready, 0);
    push_PC = 32'h10; push_inst = 32'hdead;
    step();
    push_valid = 0;
    chk("ovf_count", count, 4);
    chk("ovf_head", PC_out, 0);
    pop_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", PC_out, 64'(i * 4));
      chk("drain_inst", instruction_out, 64'(32'h1000 + 32'(i)));
      step();
    end
    pop_ready = 0;
    chk("drain_count", count, 0);
    chk("drain_valid", pop_valid, 0);
    // full with push and pop together
    push_valid = 1;
    for (int i = 0; i < 4; i++) begin
      push_PC = 32'(i * 4); push_inst = 32'h2000 + 32'(i);
      step();
    end
    push_PC = 32'h40; push_inst = 32'h2040; pop_ready = 1;
    #1;
    chk("fp_push_ready_pre", push_ready, 0);
    step();
    pop_ready = 0;
    chk("fp_count3", count, 3);
    chk("fp_head", PC_out, 32'h4);
    chk("fp_push_ready", push_ready, 1);
    step();
    push_valid = 0;
    chk("fp_count4", count, 4);
    chk("fp_head2", PC_out, 32'h4);
    // flush with push and pop at count 3
    pop_ready = 1;
    step();
    chk("pre_flush_count", count, 3);
    chk("pre_flush_head", PC_out, 32'h8);
    push_valid = 1; push_PC = 32'h80; flush = 1;
    step();
    push_valid = 0; pop_ready = 0; flush = 0;
    chk("flush_count", count, 0);
    chk("flush_valid", pop_valid, 0);
    chk("flush_inst", instruction_out, 32'h13);
    chk("flush_pc_hold", PC_out, 32'h8);
    // streaming across pointer wrap
    push_valid = 1; push_PC = 0; push_inst = 32'h3000;
    step();
    pop_ready = 1;
    for (int i = 1; i < 10; i++) begin
      push_PC = 32'(i * 4); push_inst = 32'h3000 + 32'(i);
      chk("stream_pc", PC_out, 64'((i - 1) * 4));
      chk("stream_inst", instruction_out, 64'(32'h3000 + 32'(i - 1)));
      step();
      chk("stream_count", count, 1);
    end
    push_valid = 0;
    chk("stream_last", PC_out, 32'h24);
    step();
    pop_ready = 0;
    chk("stream_end_count", count, 0);
    // asynchronous reset between edges
    push_valid = 1; push_PC = 32'h50;
    step();
    push_PC = 32'h54;
    step();
    push_valid = 0;
    chk("ar_count_pre", count, 2);
    #2 nReset = 0;
    #1;
    chk("ar_count", count, 0);
    chk("ar_valid", pop_valid, 0);
    chk("ar_push_ready", push_ready, 1);
    chk("ar_pc", PC_out, 0);
    chk("ar_inst", instruction_out, 32'h13);
    #1 nReset = 1;
    push_valid = 1; push_PC = 32'h200; push_inst = 32'h00a00113;
    step();
    push_valid = 0;
    chk("post_rst_count", count, 1);
    chk("post_rst_pc", PC_out, 32'h200);
    chk("post_rst_inst", instruction_out, 32'h00a00113);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
- REQ-001: Parameter XLEN, default 32: PC width in bits.
- REQ-002: Parameter DEPTH, default 4: entry count; power of two, >= 2.
- REQ-003: Parameter NOP, default 32'h00000013: instruction word presented when no valid entry exists.
- REQ-004: Clock  input  1  sole clock; all state updates on its rising edge.
- REQ-005: nReset  input  1  asynchronous, active-low reset.
- REQ-006: push_valid  input  1  program-memory side offers an entry this cycle.
- REQ-007: push_ready  output  1  queue accepts an entry this cycle.
- REQ-008: push_PC  input  XLEN  PC of the offered instruction.
- REQ-009: push_inst  input  32  offered instruction word.
- REQ-010: pop_valid  output  1  head entry is valid.
- REQ-011: pop_ready  input  1  decode stage consumes the head (driven as not-hold).
- REQ-012: PC_out  output  XLEN  PC of the head entry.
- REQ-013: instruction_out  output  32  instruction word of the head entry.
- REQ-014: flush  input  1  branch redirect; discards all entries.
- REQ-015: count  output  $clog2(DEPTH+1)  number of valid entries.

Function
- REQ-016: The block SHALL be a circular buffer of DEPTH {PC, instruction} entries, with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
- REQ-017: Push SHALL occur when push_valid && push_ready && !flush; the entry is written at the write pointer, which then increments.
- REQ-018: Pop SHALL occur when pop_valid && pop_ready && !flush; the read pointer then increments.
- REQ-019: push_ready SHALL equal (count != DEPTH), derived from registered state only, with no combinational path from pop_ready.
- REQ-020: pop_valid SHALL equal (count != 0).
- REQ-021: PC_out and instruction_out SHALL present the entry at the read pointer when pop_valid=1.
- REQ-022: When pop_valid=0, instruction_out SHALL be NOP and PC_out SHALL hold its last presented value.
- REQ-023: Latency SHALL be one cycle: an entry pushed at edge N is visible at the head after edge N if the queue was empty; there is no combinational bypass from push to pop.
- REQ-024: A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
- REQ-025: At full, push_ready=0 even if pop_ready=1; the pop proceeds and push_ready rises the next cycle.
- REQ-026: A push offered while push_ready=0 SHALL be ignored, and the stored contents SHALL remain unchanged.
- REQ-027: A pop requested while pop_valid=0 SHALL be ignored, and count SHALL NOT underflow.
- REQ-028: On flush=1, both pointers SHALL be reset to 0 and count SHALL be 0 at the next edge; any push or pop in the same cycle is discarded.
- REQ-029: On the cycle after a flush, pop_valid SHALL be 0 and instruction_out SHALL be NOP.
- REQ-030: count SHALL update each edge as count + push - pop, saturating only through the push_ready and pop_valid gating.

Reset
- REQ-031: While nReset=0, pointers and count SHALL be 0, pop_valid=0, push_ready=1, PC_out=0 and instruction_out=NOP, asynchronously and independent of Clock.
- REQ-032: Assertion of nReset mid-operation SHALL discard all entries immediately; storage array contents need not be cleared.
- REQ-033: After nReset deasserts, the first push SHALL be accepted on the first rising edge.

Verification (DEPTH=4)
- REQ-034: Push PC 0x00,0x04,0x08,0x0C with pop_ready=0 -> count=4, push_ready=0; a fifth push of 0x10 is ignored; pops then return 0x00..0x0C in order.
- REQ-035: Empty queue, push 0x100/inst 0x00500093 -> pop_valid=0 in that cycle; pop_valid=1 with PC_out=0x100 on the following cycle.
- REQ-036: Full queue with push_valid=1 and pop_ready=1 -> head 0x00 popped, push blocked, count=3; next cycle the push is accepted and count=4.
- REQ-037: Count=3 with push, pop and flush all asserted -> next cycle count=0, pop_valid=0, instruction_out=0x00000013.
- REQ-038: Continuous push/pop for 10 entries (PC 0x00..0x24) -> order preserved across pointer wrap and count stays constant at 1.
- REQ-039: nReset pulsed low between edges with count=2 -> count=0 and pop_valid=0 before the next edge.
